note_player: RTL



---
 rtl/note_player.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/note_player.sv
// note_player: plays one note at a time on a square-wave buzzer, lights a
// one-hot LED for the note, then holds a silent gap and pulses done.
module note_player #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DUR_UNIT   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] note_in,
    input  logic [3:0] note_len,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       stop,
    output logic       buzzer,
    output logic [6:0] led_out,
    output logic       busy,
    output logic       done
);

    // Half-period of each pitch in clock cycles (do..si)
    localparam int HALF_1 = CLK_FREQ / (2 * 262);
    localparam int HALF_2 = CLK_FREQ / (2 * 294);
    localparam int HALF_3 = CLK_FREQ / (2 * 330);
    localparam int HALF_4 = CLK_FREQ / (2 * 349);
    localparam int HALF_5 = CLK_FREQ / (2 * 392);
    localparam int HALF_6 = CLK_FREQ / (2 * 440);
    localparam int HALF_7 = CLK_FREQ / (2 * 494);

    // do has the longest half-period, so it sizes the tone counter
    localparam int TONE_W = (HALF_1 > 2) ? $clog2(HALF_1) : 1;
    localparam int DUR_W  = $clog2(16 * DUR_UNIT);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DUR_W-1:0] DUR_U    = DUR_W'(DUR_UNIT);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state;
    logic [3:0]        note_reg;
    logic [DUR_W-1:0]  dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] half_m1;
    logic [3:0]        len_eff;
    logic [DUR_W-1:0]  dur_load;
    logic              is_tone;
    logic              accept;
    logic              stay_play;

    // A zero length plays as one unit; the duration counter counts down to 0
    assign len_eff  = (note_len == 4'd0) ? 4'd1 : note_len;
    assign dur_load = DUR_W'(len_eff) * DUR_U - DUR_W'(1);

    assign is_tone    = (note_reg >= 4'd1) && (note_reg <= 4'd7);
    assign accept     = (state == S_IDLE) && note_valid && !stop;
    assign stay_play  = (state == S_PLAY) && !stop && (dur_cnt != '0);

    assign note_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign led_out    = ((state == S_PLAY) && is_tone) ? (7'd1 << (note_reg - 4'd1)) : 7'd0;

    // Terminal count of the tone divider for the latched note
    always_comb begin
        half_m1 = '0;
        case (note_reg)
            4'd1:    half_m1 = TONE_W'(HALF_1 - 1);
            4'd2:    half_m1 = TONE_W'(HALF_2 - 1);
            4'd3:    half_m1 = TONE_W'(HALF_3 - 1);
            4'd4:    half_m1 = TONE_W'(HALF_4 - 1);
            4'd5:    half_m1 = TONE_W'(HALF_5 - 1);
            4'd6:    half_m1 = TONE_W'(HALF_6 - 1);
            4'd7:    half_m1 = TONE_W'(HALF_7 - 1);
            default: half_m1 = '0;
        endcase
    end

    // Sequencing of IDLE -> PLAY -> GAP -> IDLE with abort and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            note_reg <= 4'd0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        note_reg <= note_in;
                        dur_cnt  <= dur_load;
                        state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (dur_cnt == '0) begin
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end else begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (gap_cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tone divider: toggles the buzzer every half-period while a pitched note plays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (stay_play && is_tone) begin
            if (tone_cnt == half_m1) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
        end else begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end
    end

endmodule
